uart_ram_loader: RTL
====================

Name: uart_ram_loader

Overview:
- Serial-to-memory loader upstream of the data RAM's second write port (wEn2/addr2/dataIn2).
- Receives 8N1 UART bytes on the board clock and packs them little-endian into 32-bit words.
- Writes each completed word to RAM at an auto-incrementing word address.
- The memory map supplies the start address and a set strobe; the last received byte is also exported for polling by software.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- ADDR_WIDTH, 12: RAM word-address width.
- WE_HOLD, 8: clk cycles writeEnable/writeAddr/writeData are held stable, so the clk/8 processor-domain RAM samples the write. Must satisfy WE_HOLD < 10*CLKS_PER_BIT.

Ports:
- clk  in  1  board clock. Single clock domain; everything is registered on posedge clk.
- rst  in  1  reset, asynchronous, active-low.
- serialIn  in  1  UART RX line, idle high, asynchronous to clk.
- setAddr  in  1  one-cycle strobe: load the address counter from startAddr.
- startAddr  in  ADDR_WIDTH  word address loaded on setAddr.
- writeAddr  out  ADDR_WIDTH  RAM write address.
- writeData  out  32  RAM write data.
- writeEnable  out  1  RAM write enable, held high for WE_HOLD cycles.
- lastByte  out  8  most recently accepted byte.
- byteValid  out  1  one-cycle pulse when lastByte updates.
- err  out  1  sticky framing-error flag.

Behaviour:
- Reset (async, rst=0): all outputs 0; address counter 0; byte index 0; RX FSM in IDLE; both synchronizer flops 1.
- Input sync: serialIn passes through a 2-flop synchronizer. The FSM sees only the synchronized value rx_s.
- RX FSM states and transitions:
  - IDLE: rx_s==0 → START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer division) sample rx_s.
    - 0 → DATA, counter cleared.
    - 1 → glitch; return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register. After the 8th sample → STOP.
  - STOP: sample after CLKS_PER_BIT.
    - 1 → byte accepted: lastByte loads the byte and byteValid pulses on the next cycle. → IDLE.
    - 0 → framing error: err←1, byte discarded, → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then → IDLE. Prevents a break condition from being read as 0x00 bytes.
- Word assembly, per accepted byte:
  - Byte index i (0..3) selects destination word[8i+7:8i]; byte 0 is the LSB.
  - On i==3: in the cycle after acceptance, writeData←assembled word, writeAddr←counter, and writeEnable rises. i wraps to 0.
  - Latency: writeEnable is high 2 cycles after the 4th stop-bit sample and stays high for exactly WE_HOLD cycles. Address and data are stable for that whole window.
  - The address counter increments when writeEnable falls. Wrap 2^ADDR_WIDTH−1 → 0.
- setAddr:
  - Counter←startAddr, byte index←0 (partial word discarded), err←0.
  - If asserted during a WE_HOLD window, the in-flight write completes unchanged and the post-write increment is suppressed; the counter takes startAddr.
  - If asserted in the same cycle a 4th byte is accepted, setAddr wins: no write occurs and the word is dropped.
- RX continues independently of writes. The parameter constraint guarantees a write window ends before the next word can complete.
- A framing error does not reset the byte index. The next good byte continues the current word.
- err stays set until setAddr or reset.

Test Plan (CLKS_PER_BIT=16, WE_HOLD=8):
1. Reset then setAddr with startAddr=0x010; send bytes 0x78,0x56,0x34,0x12 → exactly one write: writeAddr=0x010, writeData=0x12345678, writeEnable high for 8 cycles; byteValid pulses 4 times; lastByte=0x12.
2. Eight bytes 00..07 after setAddr(0xFFF) → writes {0xFFF: 0x03020100}, then {0x000: 0x07060504} (wrap).
3. 0-pulse of 4 cycles on serialIn in IDLE → no byteValid, no err, FSM back in IDLE.
4. Byte with stop bit 0, line held low for 40 bit times → err=1; no byteValid; no further bytes. Line high, then 0xA5 → byteValid with lastByte=0xA5. setAddr → err=0.
5. Send 2 bytes, then setAddr(0x020), then 4 bytes 11,22,33,44 → single write at 0x020 of 0x44332211.
6. Assert rst low mid-DATA of the 3rd byte → all outputs 0 immediately. After release, 4 fresh bytes produce a write at address 0.

Source files
------------

// File: rtl/uart_ram_loader.sv
// UART (8N1) receiver that packs bytes little-endian into 32-bit words and
// writes each completed word into a RAM port at an auto-incrementing address.
// The write strobe is stretched so a slower RAM clock domain can sample it.
module uart_ram_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12,
  parameter int WE_HOLD      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serialIn,
  input  logic                  setAddr,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [31:0]           writeData,
  output logic                  writeEnable,
  output logic [7:0]            lastByte,
  output logic                  byteValid,
  output logic                  err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam int HW = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(WE_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // synchronizer
  logic rx_meta;
  logic rx_s;

  // receiver
  rx_state_t     state;
  logic [CW-1:0] bit_clk;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          rx_done;
  logic          rx_ferr;

  // word assembly and write window
  logic [1:0]            byte_idx;
  logic [31:0]           word_reg;
  logic                  wr_pending;
  logic [HW-1:0]         we_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  inc_block;
  logic                  we_ending;

  // Last cycle of the write window; the address counter advances here.
  assign we_ending = writeEnable && (we_cnt == HOLD_LAST) && !wr_pending;

  // Two-flop synchronizer for the asynchronous RX line (idle high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serialIn;
      rx_s    <= rx_meta;
    end
  end

  // RX state machine: start-bit check at mid-bit, then one sample per bit time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_clk   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_done   <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            bit_clk <= '0;
          end
        end
        START: begin
          if (bit_clk == HALF_BIT) begin
            bit_clk <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
        DATA: begin
          if (bit_clk == LAST_CLK) begin
            bit_clk   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
        STOP: begin
          if (bit_clk == LAST_CLK) begin
            bit_clk <= '0;
            if (rx_s) begin
              rx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              rx_ferr <= 1'b1;
              state   <= WAIT_HIGH;
            end
          end else begin
            bit_clk <= bit_clk + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as a stream of 0x00.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte export, word packing, stretched RAM write and address counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastByte    <= '0;
      byteValid   <= 1'b0;
      err         <= 1'b0;
      byte_idx    <= '0;
      word_reg    <= '0;
      wr_pending  <= 1'b0;
      writeEnable <= 1'b0;
      writeData   <= '0;
      writeAddr   <= '0;
      we_cnt      <= '0;
      addr_cnt    <= '0;
      inc_block   <= 1'b0;
    end else begin
      byteValid  <= 1'b0;
      wr_pending <= 1'b0;

      if (rx_done) begin
        lastByte  <= shift_reg;
        byteValid <= 1'b1;
      end

      // setAddr discards any partial word, including one completing right now.
      if (setAddr) begin
        byte_idx <= '0;
        err      <= 1'b0;
      end else begin
        if (rx_ferr) begin
          err <= 1'b1;
        end
        if (rx_done) begin
          word_reg[8*byte_idx +: 8] <= shift_reg;
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            wr_pending <= 1'b1;
          end
        end
      end

      // Address and data are frozen in output registers for the whole window.
      if (wr_pending) begin
        writeEnable <= 1'b1;
        writeData   <= word_reg;
        writeAddr   <= addr_cnt;
        we_cnt      <= '0;
      end else if (writeEnable) begin
        if (we_cnt == HOLD_LAST) begin
          writeEnable <= 1'b0;
        end else begin
          we_cnt <= we_cnt + 1'b1;
        end
      end

      // A reload during an in-flight write cancels that write's post-increment.
      if (setAddr) begin
        addr_cnt  <= startAddr;
        inc_block <= (writeEnable && !we_ending) || wr_pending;
      end else if (we_ending) begin
        if (!inc_block) begin
          addr_cnt <= addr_cnt + 1'b1;
        end
        inc_block <= 1'b0;
      end
    end
  end

endmodule
